multi_digit_lock: RTL and testbench
===================================

Name: multi_digit_lock

Overview:
Parametrised keypad lock that takes a multi-digit code one digit per cycle and compares it once the full code has been entered. It limits wrong attempts with a timed alarm lockout, auto-relocks after a programmable open time, and supports master-key-authorised code change with a timeout. Successor to the single-nibble lock. Sits between the keypad debouncer/encoder and the door actuator/status LED driver.

Parameters:
DIGIT_W, 4, bits per digit
CODE_LEN, 4, digits per code (1..8)
DEFAULT_CODE, 16'h1A2B, code loaded at reset (CODE_LEN*DIGIT_W bits)
MASTER_KEY, 16'hFFFF, master key for code change (CODE_LEN*DIGIT_W bits)
MAX_TRIES, 3, wrong codes allowed before lockout
LOCKOUT_CYC, 16, alarm/lockout duration in cycles
UNLOCK_CYC, 8, cycles door_unlock stays high
HOLD_CYC, 6, consecutive cycles change_req must be held
CHG_TIMEOUT_CYC, 32, idle cycles allowed in change states before abort

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
digit_in  in  DIGIT_W  keypad digit
digit_valid  in  1  one-cycle strobe, digit_in valid
clear  in  1  discard partial entry
change_req  in  1  level; hold to request code change
master_in  in  CODE_LEN*DIGIT_W  master key candidate
master_valid  in  1  one-cycle strobe for master_in
door_unlock  out  1  actuator drive
alarm  out  1  lockout alarm
state_display  out  3  status code
digits_entered  out  $clog2(CODE_LEN+1)  digits captured in current entry
tries_left  out  $clog2(MAX_TRIES+1)  remaining attempts

Behaviour:
- Reset (asynchronous, active-high) puts the block in IDLE: door_unlock=0, alarm=0, state_display=000, digits_entered=0, tries_left=MAX_TRIES, code=DEFAULT_CODE, all counters 0. Reset mid-operation aborts everything, including a code change in progress.
- States and display codes: IDLE 000, UNLOCKED 001, ENTRY 010, LOCKOUT 011, CHG_AUTH 100, CHG_NEW 101, CHG_FAIL 110.
- IDLE/ENTRY: each digit_valid shifts digit_in in, MSB-first, and increments digits_entered. The first digit moves the block to ENTRY. The digit that completes the entry (CODE_LEN-th) triggers a compare in that same cycle; the result is registered and visible on the next edge (1-cycle latency). digits_entered then returns to 0.
- Match: go to UNLOCKED. door_unlock=1 for exactly UNLOCK_CYC cycles, then IDLE. tries_left is reloaded to MAX_TRIES.
- Mismatch: tries_left decrements. If it reaches 0, go to LOCKOUT; otherwise go to IDLE.
- LOCKOUT: alarm=1 for LOCKOUT_CYC cycles. On exit: alarm=0, tries_left=MAX_TRIES, state IDLE. All inputs are ignored during LOCKOUT.
- UNLOCKED: digit_valid is ignored. change_req is ignored.
- clear: zeroes the partial entry and returns to IDLE; no try is consumed. If clear and digit_valid arrive in the same cycle, clear wins.
- Change request: honoured only in IDLE with digits_entered=0, when change_req has been high for HOLD_CYC consecutive cycles; the hold counter resets when change_req drops. Reaching the count moves the block to CHG_AUTH.
- CHG_AUTH: on master_valid, if master_in==MASTER_KEY go to CHG_NEW. Otherwise go to CHG_FAIL, which consumes one try and can enter LOCKOUT.
- CHG_NEW: collects CODE_LEN digits. On the last digit the code register updates, tries_left is reloaded, and the block goes to IDLE.
- CHG_FAIL: held for 1 cycle, then IDLE (or LOCKOUT if tries_left is 0).
- Change timeout: CHG_TIMEOUT_CYC cycles without a strobe in CHG_AUTH or CHG_NEW aborts to IDLE with the code unchanged. clear in a change state also aborts.
- All counters saturate; none wrap.

Optional Feature:
MULTI_DIGIT_LOCK_ESCALATE_EN
- Defined: each successive lockout doubles its duration (LOCKOUT_CYC<<n, n saturates at 3). n resets only on a successful unlock or on reset.
- Undefined: every lockout lasts LOCKOUT_CYC.

Decomposition:
- Package lock_pkg: state enum, display code constants (DISP_IDLE … DISP_CHG_FAIL), and a $clog2-based width helper.
- Sub-module lock_entry_buf: digit shift register plus digits_entered counter with full/clear. It is instantiated once and shared by ENTRY and CHG_NEW.

Test Plan:
- Reset, then digits 1,A,2,B → door_unlock high for 8 cycles starting 1 cycle after the 4th digit; state_display 001, then 000.
- Wrong code 0,0,0,0 three times → tries_left 2,1,0; alarm=1 and display 011 for 16 cycles; then tries_left=3, display 000.
- Digits 1,A then clear, then 1,A,2,B → unlock; tries_left stays 3.
- change_req held 6 cycles, master FFFF, digits 5,5,5,5 → code updated; 1,A,2,B now fails, 5,5,5,5 unlocks.
- change_req held 5 cycles only → stays IDLE. Hold 6 cycles, master 0000 → display 110 for 1 cycle, tries_left 2, code unchanged.
- Assert reset mid-LOCKOUT and mid-CHG_NEW → all outputs return to reset values; DEFAULT_CODE restored. With ESCALATE_EN, a second lockout lasts 32 cycles.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared types for the multi-digit keypad lock.
// Holds the state encoding, display codes and a width helper.
package lock_pkg;

    localparam logic [2:0] DISP_IDLE     = 3'b000;
    localparam logic [2:0] DISP_UNLOCKED = 3'b001;
    localparam logic [2:0] DISP_ENTRY    = 3'b010;
    localparam logic [2:0] DISP_LOCKOUT  = 3'b011;
    localparam logic [2:0] DISP_CHG_AUTH = 3'b100;
    localparam logic [2:0] DISP_CHG_NEW  = 3'b101;
    localparam logic [2:0] DISP_CHG_FAIL = 3'b110;

    // State values equal their display codes, so the display is the state.
    typedef enum logic [2:0] {
        S_IDLE     = DISP_IDLE,
        S_UNLOCKED = DISP_UNLOCKED,
        S_ENTRY    = DISP_ENTRY,
        S_LOCKOUT  = DISP_LOCKOUT,
        S_CHG_AUTH = DISP_CHG_AUTH,
        S_CHG_NEW  = DISP_CHG_NEW,
        S_CHG_FAIL = DISP_CHG_FAIL
    } state_e;

    // Bits needed to hold the values 0..n.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/lock_entry_buf.sv
// Digit shift register and digit counter for the keypad lock.
// Shared by code entry and new-code capture; empties itself when full.
module lock_entry_buf
    import lock_pkg::*;
#(
    parameter int DIGIT_W  = 4,
    parameter int CODE_LEN = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clr_i,
    input  logic                         push_i,
    input  logic [DIGIT_W-1:0]           digit_i,
    output logic [CODE_LEN*DIGIT_W-1:0]  nxt_o,
    output logic                         last_o,
    output logic [cnt_w(CODE_LEN)-1:0]   count_o
);

    localparam int CW  = CODE_LEN * DIGIT_W;
    localparam int NW  = cnt_w(CODE_LEN);

    logic [CW-1:0] value_q, value_d;
    logic [NW-1:0] cnt_q, cnt_d;

    // Value the register would hold once the current digit is shifted in.
    assign nxt_o   = (value_q << DIGIT_W) | CW'(digit_i);
    assign last_o  = (cnt_q == NW'(CODE_LEN - 1));
    assign count_o = cnt_q;

    // Shift in MSB-first; the completing digit empties the buffer.
    always_comb begin
        value_d = value_q;
        cnt_d   = cnt_q;
        if (clr_i) begin
            value_d = '0;
            cnt_d   = '0;
        end else if (push_i) begin
            if (last_o) begin
                value_d = '0;
                cnt_d   = '0;
            end else begin
                value_d = nxt_o;
                cnt_d   = cnt_q + NW'(1);
            end
        end
    end

    // Buffer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q <= '0;
            cnt_q   <= '0;
        end else begin
            value_q <= value_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/multi_digit_lock.sv
// Multi-digit keypad lock with try limit, timed lockout and code change.
// Define MULTI_DIGIT_LOCK_ESCALATE_EN to double each successive lockout.
module multi_digit_lock
    import lock_pkg::*;
#(
    parameter int DIGIT_W         = 4,
    parameter int CODE_LEN        = 4,
    parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = 16'h1A2B,
    parameter logic [CODE_LEN*DIGIT_W-1:0] MASTER_KEY   = 16'hFFFF,
    parameter int MAX_TRIES       = 3,
    parameter int LOCKOUT_CYC     = 16,
    parameter int UNLOCK_CYC      = 8,
    parameter int HOLD_CYC        = 6,
    parameter int CHG_TIMEOUT_CYC = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DIGIT_W-1:0]           digit_in,
    input  logic                         digit_valid,
    input  logic                         clear,
    input  logic                         change_req,
    input  logic [CODE_LEN*DIGIT_W-1:0]  master_in,
    input  logic                         master_valid,
    output logic                         door_unlock,
    output logic                         alarm,
    output logic [2:0]                   state_display,
    output logic [cnt_w(CODE_LEN)-1:0]   digits_entered,
    output logic [cnt_w(MAX_TRIES)-1:0]  tries_left
);

    localparam int CW     = CODE_LEN * DIGIT_W;
    localparam int TRY_W  = cnt_w(MAX_TRIES);
    localparam int HOLD_W = cnt_w(HOLD_CYC);
`ifdef MULTI_DIGIT_LOCK_ESCALATE_EN
    localparam int LOCK_MAX = LOCKOUT_CYC << 3;
`else
    localparam int LOCK_MAX = LOCKOUT_CYC;
`endif
    localparam int T_A  = (UNLOCK_CYC > LOCK_MAX) ? UNLOCK_CYC : LOCK_MAX;
    localparam int TMAX = (T_A > CHG_TIMEOUT_CYC) ? T_A : CHG_TIMEOUT_CYC;
    localparam int TM_W = cnt_w(TMAX);

    state_e            state_q, state_d;
    logic [TM_W-1:0]   timer_q, timer_d;
    logic [TRY_W-1:0]  tries_q, tries_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [CW-1:0]     code_q, code_d;
    logic [TM_W-1:0]   lock_len;

    logic                 buf_clr, buf_push, buf_last;
    logic [CW-1:0]        buf_nxt;
    logic [cnt_w(CODE_LEN)-1:0] buf_cnt;

    lock_entry_buf #(
        .DIGIT_W  (DIGIT_W),
        .CODE_LEN (CODE_LEN)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (buf_clr),
        .push_i  (buf_push),
        .digit_i (digit_in),
        .nxt_o   (buf_nxt),
        .last_o  (buf_last),
        .count_o (buf_cnt)
    );

`ifdef MULTI_DIGIT_LOCK_ESCALATE_EN
    logic [1:0] esc_q;
    assign lock_len = TM_W'(LOCKOUT_CYC) << esc_q;

    // Count completed lockouts (saturating); a successful unlock forgets them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            esc_q <= '0;
        end else if (state_q == S_UNLOCKED) begin
            esc_q <= '0;
        end else if (state_q == S_LOCKOUT && timer_q == lock_len - TM_W'(1)
                     && esc_q != 2'd3) begin
            esc_q <= esc_q + 2'd1;
        end
    end
`else
    assign lock_len = TM_W'(LOCKOUT_CYC);
`endif

    // Next-state, counters and entry-buffer control.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        tries_d  = tries_q;
        hold_d   = '0;
        code_d   = code_q;
        buf_clr  = 1'b0;
        buf_push = 1'b0;
        unique case (state_q)
            S_IDLE, S_ENTRY: begin
                if (clear) begin
                    buf_clr = 1'b1;
                    state_d = S_IDLE;
                end else if (digit_valid) begin
                    buf_push = 1'b1;
                    state_d  = S_ENTRY;
                    if (buf_last) begin
                        timer_d = '0;
                        if (buf_nxt == code_q) begin
                            state_d = S_UNLOCKED;
                            tries_d = TRY_W'(MAX_TRIES);
                        end else begin
                            if (tries_q != '0) tries_d = tries_q - TRY_W'(1);
                            state_d = (tries_q <= TRY_W'(1)) ? S_LOCKOUT : S_IDLE;
                        end
                    end
                end else if (state_q == S_IDLE && buf_cnt == '0 && change_req) begin
                    if (hold_q == HOLD_W'(HOLD_CYC - 1)) begin
                        state_d = S_CHG_AUTH;
                        timer_d = '0;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
            end
            S_UNLOCKED: begin
                if (timer_q == TM_W'(UNLOCK_CYC - 1)) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TM_W'(1);
                end
            end
            S_LOCKOUT: begin
                if (timer_q == lock_len - TM_W'(1)) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                    tries_d = TRY_W'(MAX_TRIES);
                end else begin
                    timer_d = timer_q + TM_W'(1);
                end
            end
            S_CHG_AUTH: begin
                if (clear) begin
                    buf_clr = 1'b1;
                    state_d = S_IDLE;
                    timer_d = '0;
                end else if (master_valid) begin
                    timer_d = '0;
                    if (master_in == MASTER_KEY) begin
                        state_d = S_CHG_NEW;
                    end else begin
                        state_d = S_CHG_FAIL;
                        if (tries_q != '0) tries_d = tries_q - TRY_W'(1);
                    end
                end else if (timer_q == TM_W'(CHG_TIMEOUT_CYC - 1)) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TM_W'(1);
                end
            end
            S_CHG_NEW: begin
                if (clear) begin
                    buf_clr = 1'b1;
                    state_d = S_IDLE;
                    timer_d = '0;
                end else if (digit_valid) begin
                    buf_push = 1'b1;
                    timer_d  = '0;
                    if (buf_last) begin
                        code_d  = buf_nxt;
                        tries_d = TRY_W'(MAX_TRIES);
                        state_d = S_IDLE;
                    end
                end else if (timer_q == TM_W'(CHG_TIMEOUT_CYC - 1)) begin
                    buf_clr = 1'b1;
                    state_d = S_IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TM_W'(1);
                end
            end
            S_CHG_FAIL: begin
                timer_d = '0;
                state_d = (tries_q == '0) ? S_LOCKOUT : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase
    end

    // State, counter and stored-code registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            tries_q <= TRY_W'(MAX_TRIES);
            hold_q  <= '0;
            code_q  <= DEFAULT_CODE;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            tries_q <= tries_d;
            hold_q  <= hold_d;
            code_q  <= code_d;
        end
    end

    assign door_unlock    = (state_q == S_UNLOCKED);
    assign alarm          = (state_q == S_LOCKOUT);
    assign state_display  = state_q;
    assign digits_entered = buf_cnt;
    assign tries_left     = tries_q;

endmodule

// File: tb/tb_multi_digit_lock.sv
// Self-checking bench for multi_digit_lock.
// Behavioural model compared every cycle plus literal expectations.
module tb_multi_digit_lock;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  digit_in = '0;
    logic        digit_valid = 1'b0;
    logic        clear = 1'b0;
    logic        change_req = 1'b0;
    logic [15:0] master_in = '0;
    logic        master_valid = 1'b0;
    logic        door_unlock, alarm;
    logic [2:0]  state_display;
    logic [2:0]  digits_entered;
    logic [1:0]  tries_left;

    int checks = 0;
    int failures = 0;

    multi_digit_lock dut (
        .clk            (clk),
        .reset          (reset),
        .digit_in       (digit_in),
        .digit_valid    (digit_valid),
        .clear          (clear),
        .change_req     (change_req),
        .master_in      (master_in),
        .master_valid   (master_valid),
        .door_unlock    (door_unlock),
        .alarm          (alarm),
        .state_display  (state_display),
        .digits_entered (digits_entered),
        .tries_left     (tries_left)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int M_IDLE = 0, M_UNL = 1, M_ENT = 2, M_LOCK = 3;
    localparam int M_AUTH = 4, M_NEW = 5, M_FAIL = 6;

    int          m_mode, m_rem, m_tries, m_hold, m_idle, m_esc;
    logic [15:0] m_code;
    logic [3:0]  m_q[$];

    function automatic logic [15:0] q_val();
        logic [15:0] v = '0;
        foreach (m_q[i]) v = (v << 4) | 16'(m_q[i]);
        return v;
    endfunction

    function automatic int lock_time();
`ifdef MULTI_DIGIT_LOCK_ESCALATE_EN
        return 16 << m_esc;
`else
        return 16;
`endif
    endfunction

    task automatic go_lock();
        m_mode = M_LOCK;
        m_rem  = lock_time();
    endtask

    task automatic model_step();
        int hold_next = 0;
        if (reset) begin
            m_mode = M_IDLE; m_rem = 0; m_tries = 3; m_hold = 0;
            m_idle = 0; m_esc = 0; m_code = 16'h1A2B; m_q.delete();
            return;
        end
        case (m_mode)
            M_IDLE, M_ENT: begin
                if (clear) begin
                    m_q.delete(); m_mode = M_IDLE;
                end else if (digit_valid) begin
                    m_q.push_back(digit_in);
                    m_mode = M_ENT;
                    if (m_q.size() == 4) begin
                        if (q_val() == m_code) begin
                            m_mode = M_UNL; m_rem = 8; m_tries = 3; m_esc = 0;
                        end else begin
                            if (m_tries > 0) m_tries--;
                            if (m_tries == 0) go_lock();
                            else m_mode = M_IDLE;
                        end
                        m_q.delete();
                    end
                end else if (m_mode == M_IDLE && m_q.size() == 0 && change_req) begin
                    hold_next = m_hold + 1;
                    if (hold_next == 6) begin
                        hold_next = 0; m_mode = M_AUTH; m_idle = 0;
                    end
                end
            end
            M_UNL: begin
                m_rem--;
                if (m_rem == 0) m_mode = M_IDLE;
            end
            M_LOCK: begin
                m_rem--;
                if (m_rem == 0) begin
                    m_mode = M_IDLE; m_tries = 3;
                    if (m_esc < 3) m_esc++;
                end
            end
            M_AUTH: begin
                if (clear) m_mode = M_IDLE;
                else if (master_valid) begin
                    m_idle = 0;
                    if (master_in == 16'hFFFF) m_mode = M_NEW;
                    else begin
                        m_mode = M_FAIL;
                        if (m_tries > 0) m_tries--;
                    end
                end else begin
                    m_idle++;
                    if (m_idle == 32) m_mode = M_IDLE;
                end
            end
            M_NEW: begin
                if (clear) begin
                    m_q.delete(); m_mode = M_IDLE;
                end else if (digit_valid) begin
                    m_idle = 0;
                    m_q.push_back(digit_in);
                    if (m_q.size() == 4) begin
                        m_code = q_val(); m_tries = 3;
                        m_mode = M_IDLE; m_q.delete();
                    end
                end else begin
                    m_idle++;
                    if (m_idle == 32) begin
                        m_q.delete(); m_mode = M_IDLE;
                    end
                end
            end
            M_FAIL: begin
                if (m_tries == 0) go_lock();
                else m_mode = M_IDLE;
            end
            default: m_mode = M_IDLE;
        endcase
        m_hold = hold_next;
    endtask

    // Advance the model on each edge and compare shortly after.
    always @(posedge clk) begin
        model_step();
        #1;
        chk("door_unlock", int'(door_unlock), int'(m_mode == M_UNL));
        chk("alarm", int'(alarm), int'(m_mode == M_LOCK));
        chk("state_display", int'(state_display), m_mode);
        chk("digits_entered", int'(digits_entered), m_q.size());
        chk("tries_left", int'(tries_left), m_tries);
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic key(input logic [3:0] d);
        digit_in = d; digit_valid = 1'b1;
        @(negedge clk);
        digit_valid = 1'b0;
    endtask

    task automatic code4(input logic [15:0] v);
        for (int i = 3; i >= 0; i--) key(v[i*4 +: 4]);
    endtask

    task automatic hold_chg(input int n);
        change_req = 1'b1;
        tick(n);
        change_req = 1'b0;
    endtask

    task automatic master(input logic [15:0] v);
        master_in = v; master_valid = 1'b1;
        @(negedge clk);
        master_valid = 1'b0;
    endtask

    // Count consecutive cycles a flag stays high, bounded.
    task automatic run_len(input bit use_alarm, output int n);
        n = 0;
        while ((use_alarm ? alarm : door_unlock) && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        tick(2);
        chk("reset_disp", int'(state_display), 0);
        chk("reset_tries", int'(tries_left), 3);
        chk("reset_unlock", int'(door_unlock), 0);
        reset = 1'b0;
        tick(1);

        key(4'h1);
        chk("one_digit", int'(digits_entered), 1);
        chk("entry_disp", int'(state_display), 2);
        key(4'hA); key(4'h2); key(4'hB);
        chk("unlock_disp", int'(state_display), 1);
        run_len(1'b0, n);
        chk("unlock_len", n, 8);
        chk("after_unlock", int'(state_display), 0);

        code4(16'h0000);
        chk("tries_2", int'(tries_left), 2);
        code4(16'h0000);
        chk("tries_1", int'(tries_left), 1);
        code4(16'h0000);
        chk("lock_disp", int'(state_display), 3);
        run_len(1'b1, n);
        chk("lock_len", n, 16);
        chk("lock_exit_tries", int'(tries_left), 3);

        key(4'h1); key(4'hA);
        clear = 1'b1; tick(1); clear = 1'b0;
        chk("clear_cnt", int'(digits_entered), 0);
        code4(16'h1A2B);
        chk("clear_unlock", int'(door_unlock), 1);
        chk("clear_tries", int'(tries_left), 3);
        run_len(1'b0, n);

        hold_chg(6);
        chk("chg_auth", int'(state_display), 4);
        master(16'hFFFF);
        chk("chg_new", int'(state_display), 5);
        code4(16'h5555);
        chk("chg_done", int'(state_display), 0);
        code4(16'h1A2B);
        chk("old_code_fails", int'(tries_left), 2);
        code4(16'h5555);
        chk("new_code_opens", int'(door_unlock), 1);
        run_len(1'b0, n);

        hold_chg(5);
        tick(1);
        chk("short_hold", int'(state_display), 0);
        hold_chg(6);
        master(16'h0000);
        chk("chg_fail_disp", int'(state_display), 6);
        chk("chg_fail_tries", int'(tries_left), 2);
        tick(1);
        chk("chg_fail_exit", int'(state_display), 0);
        code4(16'h5555);
        chk("code_kept", int'(door_unlock), 1);
        run_len(1'b0, n);

        hold_chg(6);
        tick(31);
        chk("timeout_wait", int'(state_display), 4);
        tick(1);
        chk("timeout_abort", int'(state_display), 0);

        code4(16'h0000); code4(16'h0000); code4(16'h0000);
        tick(3);
        reset = 1'b1; tick(1);
        chk("rst_lock_alarm", int'(alarm), 0);
        chk("rst_lock_tries", int'(tries_left), 3);
        reset = 1'b0;
        hold_chg(6);
        master(16'hFFFF);
        key(4'h7); key(4'h7);
        reset = 1'b1; tick(1);
        chk("rst_new_cnt", int'(digits_entered), 0);
        chk("rst_new_disp", int'(state_display), 0);
        reset = 1'b0;
        code4(16'h1A2B);
        chk("default_back", int'(door_unlock), 1);
        run_len(1'b0, n);

        code4(16'h0000); code4(16'h0000); code4(16'h0000);
        run_len(1'b1, n);
        chk("lock1_len", n, 16);
        code4(16'h0000); code4(16'h0000); code4(16'h0000);
        run_len(1'b1, n);
`ifdef MULTI_DIGIT_LOCK_ESCALATE_EN
        chk("lock2_len", n, 32);
`else
        chk("lock2_len", n, 16);
`endif
        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
